// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared state encoding, exception codes and timeout default
// for the fp_mul_driver slice.
`default_nettype none

package fp_mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [2:0] EXC_NONE    = 3'b000;
  localparam logic [2:0] EXC_TIMEOUT = 3'b111;

  localparam int TIMEOUT_CYCLES_DEFAULT = 200;

endpackage : fp_mul_pkg

`default_nettype wire

// File: rtl/fp_mul_watchdog.sv
// fp_mul_watchdog: counts WAIT cycles and flags the last permitted one.
// Revision: 1.0
`default_nettype none

module fp_mul_watchdog
  import fp_mul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Asserted during the TIMEOUT_CYCLES-th WAIT cycle, so the count reaches
  // TIMEOUT_CYCLES on the edge that leaves WAIT.
  assign o_expired = i_en && (r_cnt == c_LAST);

endmodule : fp_mul_watchdog

`default_nettype wire

// File: rtl/fp_mul_driver.sv
// fp_mul_driver: serialises an FP multiply request onto a two-beat operand bus
// and returns the product; FP_MUL_TIMEOUT_EN adds a WAIT-state abort.
// Revision: 1.0
`default_nettype none

module fp_mul_driver
  import fp_mul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_exc,
  output logic        rsp_timeout,
  output logic        mul_ready,
  output logic [31:0] mul_op,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  input  logic [2:0]  mul_exc
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_mul_ready;
  logic [31:0] r_mul_op;
  logic [31:0] r_rsp_result;
  logic [2:0]  r_rsp_exc;
  logic        w_accept;
  logic        w_done;
  logic        w_expire;
  logic        w_mul_ready_d;
  logic [31:0] w_mul_op_d;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_done   = mul_done && (r_state == ST_WAIT);

`ifdef FP_MUL_TIMEOUT_EN
  logic r_rsp_timeout;

  fp_mul_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state == ST_SEND_B),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_expire)
  );

  // mul_done wins over a simultaneous expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_done) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_expire) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_expire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SEND_A;
      ST_SEND_A: w_next = ST_SEND_B;
      ST_SEND_B: w_next = ST_WAIT;
      ST_WAIT:   if (w_done || w_expire) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Operand-bus values are computed from the next state so they appear
  // registered in the cycle the FSM occupies SEND_A / SEND_B.
  always_comb begin
    w_mul_ready_d = 1'b0;
    w_mul_op_d    = 32'd0;
    case (w_next)
      ST_SEND_A: begin
        w_mul_ready_d = 1'b1;
        w_mul_op_d    = req_a;
      end
      ST_SEND_B: w_mul_op_d = r_b;
      default: begin
        w_mul_ready_d = 1'b0;
        w_mul_op_d    = 32'd0;
      end
    endcase
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign mul_ready  = r_mul_ready;
  assign mul_op     = r_mul_op;
  assign rsp_result = r_rsp_result;
  assign rsp_exc    = r_rsp_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_ready <= 1'b0;
      r_mul_op    <= 32'd0;
    end else begin
      r_mul_ready <= w_mul_ready_d;
      r_mul_op    <= w_mul_op_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= 32'd0;
      r_b <= 32'd0;
    end else if (w_accept) begin
      r_a <= req_a;
      r_b <= req_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= 32'd0;
      r_rsp_exc    <= EXC_NONE;
    end else if (w_done) begin
      r_rsp_result <= mul_result;
      r_rsp_exc    <= mul_exc;
    end else if (w_expire) begin
      r_rsp_result <= 32'd0;
      r_rsp_exc    <= EXC_TIMEOUT;
    end
  end

  // r_a is held for debug visibility of the accepted request.
  logic w_unused;
  assign w_unused = ^r_a;

endmodule : fp_mul_driver

`default_nettype wire

// File: tb/tb_fp_mul_driver.sv
// tb_fp_mul_driver: directed self-checking bench for fp_mul_driver.
// Revision: 1.0
`default_nettype none

module tb_fp_mul_driver;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_exc;
  logic        rsp_timeout;
  logic        mul_ready;
  logic [31:0] mul_op;
  logic        mul_done;
  logic [31:0] mul_result;
  logic [2:0]  mul_exc;

  int n_chk;
  int n_fail;

  fp_mul_driver #(
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_exc     (rsp_exc),
    .rsp_timeout (rsp_timeout),
    .mul_ready   (mul_ready),
    .mul_op      (mul_op),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .mul_exc     (mul_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a request and walk through SEND_A/SEND_B; returns in the first WAIT cycle.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    check({tag, " req_ready idle"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_a     = 32'h1111_1111;
    req_b     = 32'h2222_2222;
    check({tag, " sendA ready"}, mul_ready, 1);
    check({tag, " sendA op"}, mul_op, a);
    check({tag, " sendA req_ready"}, req_ready, 0);
    tick();
    check({tag, " sendB ready"}, mul_ready, 0);
    check({tag, " sendB op"}, mul_op, b);
    tick();
    check({tag, " wait op"}, mul_op, 0);
    check({tag, " wait ready"}, mul_ready, 0);
    check({tag, " wait rsp_valid"}, rsp_valid, 0);
  endtask

  task automatic pulse_done(input logic [31:0] r, input logic [2:0] e);
    mul_done   = 1'b1;
    mul_result = r;
    mul_exc    = e;
    tick();
    mul_done   = 1'b0;
    mul_result = 32'hDEAD_BEEF;
    mul_exc    = 3'b010;
  endtask

  // Checks a response held for bp cycles, then completes the handshake.
  task automatic respond(input string tag, input logic [31:0] r, input logic [2:0] e,
                         input logic to, input int bp);
    check({tag, " rsp_valid"}, rsp_valid, 1);
    check({tag, " rsp_result"}, rsp_result, r);
    check({tag, " rsp_exc"}, {29'd0, rsp_exc}, {29'd0, e});
    check({tag, " rsp_timeout"}, rsp_timeout, to);
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, " bp rsp_valid"}, rsp_valid, 1);
      check({tag, " bp result"}, rsp_result, r);
      check({tag, " bp exc"}, {29'd0, rsp_exc}, {29'd0, e});
      check({tag, " bp req_ready"}, req_ready, 0);
      check({tag, " bp mul_ready"}, mul_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " done rsp_valid"}, rsp_valid, 0);
    check({tag, " done req_ready"}, req_ready, 1);
    check({tag, " retained result"}, rsp_result, r);
    check({tag, " retained exc"}, {29'd0, rsp_exc}, {29'd0, e});
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    rsp_ready  = 1'b0;
    mul_done   = 1'b0;
    mul_result = 32'd0;
    mul_exc    = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset mul_ready", mul_ready, 0);
    check("reset mul_op", mul_op, 0);
    check("reset rsp_result", rsp_result, 0);
    check("reset rsp_exc", {29'd0, rsp_exc}, 0);
    check("reset rsp_timeout", rsp_timeout, 0);

    // 2.0 * 3.0 = 6.0, multiplier answers in the first WAIT cycle
    issue("basic", 32'h4000_0000, 32'h4040_0000);
    pulse_done(32'h40C0_0000, 3'b000);
    respond("basic", 32'h40C0_0000, 3'b000, 1'b0, 0);

    // Backpressure with a 3-cycle multiplier latency
    issue("bp", 32'h3F80_0000, 32'hC000_0000);
    repeat (3) begin
      tick();
      check("bp wait rsp_valid", rsp_valid, 0);
    end
    pulse_done(32'hC000_0000, 3'b000);
    respond("bp", 32'hC000_0000, 3'b000, 1'b0, 5);

    // Exception pass-through
    issue("exc", 32'h7F80_0000, 32'h0000_0000);
    pulse_done(32'h0000_0000, 3'b101);
    respond("exc", 32'h0000_0000, 3'b101, 1'b0, 1);

    // Stray mul_done in IDLE
    mul_done   = 1'b1;
    mul_result = 32'h1234_5678;
    mul_exc    = 3'b011;
    tick();
    mul_done   = 1'b0;
    check("stray rsp_valid", rsp_valid, 0);
    check("stray req_ready", req_ready, 1);
    check("stray result", rsp_result, 0);
    check("stray mul_ready", mul_ready, 0);

    // Reset while waiting on the multiplier
    issue("rstwait", 32'h4100_0000, 32'h4100_0000);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst async mul_op", mul_op, 0);
    check("rst async req_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    pulse_done(32'hFFFF_FFFF, 3'b111);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst req_ready", req_ready, 1);
    check("rst result", rsp_result, 0);
    check("rst exc", {29'd0, rsp_exc}, 0);
    check("rst timeout", rsp_timeout, 0);
    issue("postrst", 32'h4100_0000, 32'h4100_0000);
    pulse_done(32'h4280_0000, 3'b000);
    respond("postrst", 32'h4280_0000, 3'b000, 1'b0, 0);

`ifdef FP_MUL_TIMEOUT_EN
    // No mul_done: abort after exactly 200 WAIT cycles
    issue("tmo", 32'h4000_0000, 32'h4000_0000);
    repeat (199) tick();
    check("tmo still waiting", rsp_valid, 0);
    tick();
    mul_done   = 1'b1;
    mul_result = 32'hABCD_0000;
    mul_exc    = 3'b001;
    tick();
    mul_done   = 1'b0;
    respond("tmo", 32'h0000_0000, 3'b111, 1'b1, 1);

    // mul_done in the expiry cycle takes priority
    issue("prio", 32'h4000_0000, 32'h4040_0000);
    repeat (199) tick();
    pulse_done(32'h40C0_0000, 3'b000);
    respond("prio", 32'h40C0_0000, 3'b000, 1'b0, 0);
`else
    // Without the watchdog WAIT outlasts the timeout window
    issue("notmo", 32'h4000_0000, 32'h4000_0000);
    repeat (210) tick();
    check("notmo still waiting", rsp_valid, 0);
    pulse_done(32'h4080_0000, 3'b000);
    respond("notmo", 32'h4080_0000, 3'b000, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fp_mul_driver

`default_nettype wire
